mux_arb_n: RTL and testbench
============================

# mux_arb_n

Parametrised N-channel arbitrating multiplexer with valid/ready handshakes and a registered output stage; the sequential successor to the two-input combinational mux used across the datapath. It picks one of CHANNELS requesting sources each cycle (round-robin or fixed priority) and forwards one WIDTH-bit beat per cycle to a single consumer. A grant stays locked to one channel across a multi-beat packet until the last beat. It sits between multiple producers (fetch, load/store, DMA-style requesters) and a shared bus or writeback port.

## Interface
- WIDTH, 32, data bits per beat
- CHANNELS, 4, number of input channels; legal range 2..16
- SEL_W, $clog2(CHANNELS), width of the channel index; derived, never overridden
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel beat valid
- in_last  input  CHANNELS  per-channel end-of-packet flag, qualified by in_valid
- in_ready  output  CHANNELS  per-channel accept; at most one bit set
- out_data  output  WIDTH  registered beat
- out_sel  output  SEL_W  channel index of the beat in out_data
- out_last  output  1  registered copy of the accepted in_last
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat

## Operation
- State: output register (out_*), `locked` flag, `lock_ch` (SEL_W), round-robin pointer `ptr` (SEL_W).
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, out_last=0, locked=0, lock_ch=0, ptr=0; in_ready=0 while reset is asserted.
- load_en = !out_valid || out_ready. A new beat loads only when load_en=1.
- Eligibility: if locked, only lock_ch is eligible. Otherwise every channel with in_valid=1 is eligible.
- Grant, combinational, one-hot:
  - Unlocked, mode=0: first eligible channel scanning ptr, ptr+1, … with wrap modulo CHANNELS.
  - Unlocked, mode=1: lowest-index eligible channel.
  - Locked: lock_ch if in_valid[lock_ch]=1, else none.
- in_ready[i] = load_en && grant[i]. This is a valid-to-ready combinational path by design. Producers must not make in_valid depend on in_ready.
- Transfer on channel g when in_valid[g] && in_ready[g]: out_data<=in_data[g], out_sel<=g, out_last<=in_last[g], out_valid<=1.
- If load_en=1, out_valid=1, out_ready=1 and nothing transfers: out_valid<=0.
- If out_valid=1 and out_ready=0: out_data, out_sel, out_last are held stable and in_ready=0.
- Lock FSM (two states):
  - UNLOCKED→LOCKED on a transfer with in_last=0; lock_ch<=g.
  - LOCKED→UNLOCKED on a transfer with in_last=1.
  - A transfer with in_last=1 while UNLOCKED (single-beat packet) stays UNLOCKED.
- Pointer: on every transfer with in_last=1, ptr<=(g+1) mod CHANNELS, in both modes. In mode=1 the pointer is unused but still tracked, so switching to round-robin is deterministic.
- A locked channel that drops in_valid mid-packet stalls the arbiter; other channels are not granted until its last beat.
- A mode change takes effect at the next unlocked arbitration. It never breaks an active lock.
- Non-power-of-two CHANNELS: the wrap uses modulo CHANNELS; indices ≥CHANNELS are never granted.

## Timing
- Latency: 1 cycle from the accepting edge to out_valid/out_data.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously; there are no bubbles between packets or on a channel switch.
- Arbitration is re-evaluated every cycle in which load_en=1.
- Reset mid-packet: the lock and the in-flight beat are discarded. After release, arbitration restarts at channel 0.

## Test plan
- Reset: assert reset_n=0 asynchronously mid-cycle with out_valid=1 → out_valid, out_sel, out_last, out_data read 0 immediately; after release, with all 4 channels valid, single-beat and mode=0, out_sel sequence is 0,1,2,3,0.
- Round-robin fairness: CHANNELS=4, channels 1 and 3 always valid with single-beat packets, out_ready=1 → out_sel alternates 1,3,1,3; one beat per cycle with no gaps.
- Fixed priority: mode=1, channels 0 and 2 always valid → out_sel stays 0; channel 2's in_ready is never asserted until channel 0 drops in_valid.
- Packet lock: channel 2 sends 3 beats (in_last on beat 3) while channel 0 is also valid; channel 2 drops in_valid for 2 cycles mid-packet → out_sel=2 for all 3 beats, no channel-0 grant during the stall, and the next grant goes to channel 0 via wrap from ptr=3.
- Backpressure: hold out_ready=0 for 5 cycles with data 0xDEADBEEF on out_data → out_data, out_sel and out_last are stable and in_ready=0 throughout; the beat completes on the first out_ready=1 cycle and the next beat loads in that same cycle.
- Mode switch while locked: set mode 0→1 during channel 3's packet → lock is held to the last beat, then the lowest valid index is granted.

Source files
------------

// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_n
// Brief    : N-channel round-robin / fixed-priority arbitrating mux with
//            packet lock and a registered valid/ready output stage.
// Revision : 1.0
// ============================================================================
module mux_arb_n #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_lock_ch;
  logic [SEL_W-1:0]   r_ptr;
  logic               r_out_valid;
  logic               r_out_last;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_sel;

  logic               w_load_en;
  logic               w_gnt_any;
  logic               w_xfer;
  logic [SEL_W-1:0]   w_gnt_idx;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [CHANNELS-1:0] w_elig;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_last;
  int                 w_dist;
  int                 w_best;

  assign w_load_en = !r_out_valid || out_ready;
  assign w_xfer    = reset_n && w_load_en && w_gnt_any;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_elig[i] = in_valid[i] && ((r_state == ST_UNLOCKED) || (r_lock_ch == SEL_W'(i)));
    end
  end

  // Winner is the eligible channel with the smallest priority distance:
  // its index in fixed mode, its rotated distance from r_ptr in round-robin.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_best    = CHANNELS;
    w_dist    = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode) begin
        w_dist = i;
      end else begin
        w_dist = i - int'(r_ptr);
        if (w_dist < 0) begin
          w_dist = w_dist + CHANNELS;
        end
      end
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_idx = SEL_W'(i);
        w_gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt_idx == SEL_W'(i)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        w_sel_last  = in_last[i];
        in_ready[i] = w_xfer;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_UNLOCKED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNLOCKED: if (w_xfer && !w_sel_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED:   if (w_xfer &&  w_sel_last) w_state_nxt = ST_UNLOCKED;
      default:     w_state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_last  <= 1'b0;
      r_lock_ch   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_gnt_idx;
      r_out_last  <= w_sel_last;
      if (w_sel_last) begin
        r_ptr <= w_ptr_nxt;
      end else begin
        r_lock_ch <= w_gnt_idx;
      end
    end else if (w_load_en) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arb_n
// Brief    : Directed and randomized bench for mux_arb_n against a
//            behavioural arbitration model.
// Revision : 1.0
// ============================================================================
module tb_mux_arb_n;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           mode;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model state
  bit         m_ov      = 1'b0;
  bit         m_ol      = 1'b0;
  bit         m_locked  = 1'b0;
  logic [W-1:0] m_od    = '0;
  int         m_os      = 0;
  int         m_lock_ch = 0;
  int         m_ptr     = 0;

  mux_arb_n #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the arbitration rules pick this cycle, or -1 for none.
  function automatic int m_grant();
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    if (mode) begin
      for (int c = 0; c < N; c++) if (in_valid[c]) return c;
    end else begin
      for (int k = 0; k < N; k++) if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = m_grant();
    if (reset_n && (!m_ov || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin : p_model
    int g;
    if (!reset_n) begin
      m_ov <= 1'b0; m_od <= '0; m_os <= 0; m_ol <= 1'b0;
      m_locked <= 1'b0; m_lock_ch <= 0; m_ptr <= 0;
    end else begin
      g = m_grant();
      if ((!m_ov || out_ready) && g >= 0) begin
        m_ov <= 1'b1;
        m_od <= in_data[g*W +: W];
        m_os <= g;
        m_ol <= in_last[g];
        if (in_last[g]) begin
          m_locked <= 1'b0;
          m_ptr    <= (g + 1) % N;
        end else begin
          m_locked  <= 1'b1;
          m_lock_ch <= g;
        end
      end else if (!m_ov || out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("cmp_out_data", 64'(out_data), 64'(m_od));
        chk("cmp_out_sel",  64'(out_sel),  64'(m_os));
        chk("cmp_out_last", 64'(out_last), 64'(m_ol));
      end
      chk("cmp_in_ready", 64'(in_ready), 64'(exp_ready()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [N-1:0] v, input logic [N-1:0] l);
    in_valid = v;
    in_last  = l;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] d);
    in_data[i*W +: W] = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    set_all(4'hF, 4'hF);
    for (int i = 0; i < N; i++) set_ch(i, 32'hA0A0_0000 + 32'(i));
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);

    reset_n = 1'b1;
    chk_on  = 1'b1;
    repeat (2) step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_sel",   64'(out_sel),   64'd1);

    // Asynchronous reset in the middle of a cycle
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_sel",   64'(out_sel),   64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    chk("arst_out_last",  64'(out_last),  64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_after_rst_sel",   64'(out_sel),   64'(k % 4));
      chk("rr_after_rst_valid", 64'(out_valid), 64'd1);
    end

    // Round-robin between channels 1 and 3
    set_all(4'b1010, 4'hF);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_fair_sel",   64'(out_sel),   (k % 2 == 0) ? 64'd1 : 64'd3);
      chk("rr_fair_valid", 64'(out_valid), 64'd1);
    end

    // Fixed priority
    mode = 1'b1;
    set_all(4'b0101, 4'hF);
    for (int k = 0; k < 4; k++) begin
      #1 chk("fp_in_ready", 64'(in_ready), 64'b0001);
      step();
      chk("fp_sel", 64'(out_sel), 64'd0);
    end
    set_all(4'b0100, 4'hF);
    #1 chk("fp_drop_ready", 64'(in_ready), 64'b0100);
    step();
    chk("fp_drop_sel", 64'(out_sel), 64'd2);

    // Packet lock on channel 2 with a two-cycle stall
    mode = 1'b0;
    set_ch(2, 32'h2222_0001);
    set_all(4'b0100, 4'b0000);
    step();
    chk("lock_b1_sel",  64'(out_sel),  64'd2);
    chk("lock_b1_data", 64'(out_data), 64'h2222_0001);
    chk("lock_b1_last", 64'(out_last), 64'd0);
    set_all(4'b0001, 4'b0000);
    repeat (2) begin
      #1 chk("lock_stall_ready", 64'(in_ready), 64'd0);
      step();
      chk("lock_stall_valid", 64'(out_valid), 64'd0);
    end
    set_ch(2, 32'h2222_0002);
    set_all(4'b0101, 4'b0000);
    #1 chk("lock_b2_ready", 64'(in_ready), 64'b0100);
    step();
    chk("lock_b2_sel",  64'(out_sel),  64'd2);
    chk("lock_b2_data", 64'(out_data), 64'h2222_0002);
    set_ch(2, 32'h2222_0003);
    set_all(4'b0101, 4'b0100);
    step();
    chk("lock_b3_sel",  64'(out_sel),  64'd2);
    chk("lock_b3_last", 64'(out_last), 64'd1);
    chk("lock_b3_data", 64'(out_data), 64'h2222_0003);
    set_all(4'b0101, 4'b0101);
    step();
    chk("lock_wrap_sel", 64'(out_sel), 64'd0);

    // Backpressure
    set_ch(1, 32'hDEAD_BEEF);
    set_all(4'b0010, 4'b0010);
    step();
    chk("bp_load_data", 64'(out_data), 64'hDEAD_BEEF);
    out_ready = 1'b0;
    set_ch(1, 32'h1234_5678);
    repeat (5) begin
      #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("bp_hold_data",  64'(out_data),  64'hDEAD_BEEF);
      chk("bp_hold_sel",   64'(out_sel),   64'd1);
      chk("bp_hold_last",  64'(out_last),  64'd1);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'b0010);
    step();
    chk("bp_next_data",  64'(out_data),  64'h1234_5678);
    chk("bp_next_valid", 64'(out_valid), 64'd1);

    // Mode switch while channel 3 holds the lock
    mode = 1'b0;
    set_ch(3, 32'h3333_0001);
    set_all(4'b1000, 4'b0000);
    step();
    chk("ms_b1_sel", 64'(out_sel), 64'd3);
    mode = 1'b1;
    set_all(4'b1011, 4'b0000);
    #1 chk("ms_locked_ready", 64'(in_ready), 64'b1000);
    step();
    chk("ms_b2_sel", 64'(out_sel), 64'd3);
    set_all(4'b1011, 4'b1000);
    step();
    chk("ms_b3_sel",  64'(out_sel),  64'd3);
    chk("ms_b3_last", 64'(out_last), 64'd1);
    set_all(4'b1011, 4'b1011);
    step();
    chk("ms_fp_sel", 64'(out_sel), 64'd0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = N'($urandom());
      in_last   = N'($urandom()) & N'($urandom());
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) set_ch(i, $urandom());
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if (cyc == 1500) begin
        #2 reset_n = 1'b0;
        #1 chk("rand_arst_valid", 64'(out_valid), 64'd0);
        step();
        reset_n = 1'b1;
      end
      step();
    end

    set_all(4'b0000, 4'b0000);
    repeat (3) step();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
